// File: rtl/tinyrv1_mem_responder_if.sv
// TinyRV1 memory responder request/response bundle.
// master = processor side, slave = memory side.
interface tinyrv1_mem_responder_if;
   logic        imemreq_val;
   logic        imemreq_rdy;
   logic [31:0] imemreq_addr;
   logic        imemresp_val;
   logic [31:0] imemresp_data;
   logic        dmemreq_val;
   logic        dmemreq_rdy;
   logic        dmemreq_type;
   logic [31:0] dmemreq_addr;
   logic [31:0] dmemreq_wdata;
   logic        dmemresp_val;
   logic [31:0] dmemresp_data;

   modport master (
      output imemreq_val,
      output imemreq_addr,
      input  imemreq_rdy,
      input  imemresp_val,
      input  imemresp_data,
      output dmemreq_val,
      output dmemreq_type,
      output dmemreq_addr,
      output dmemreq_wdata,
      input  dmemreq_rdy,
      input  dmemresp_val,
      input  dmemresp_data
   );

   modport slave (
      input  imemreq_val,
      input  imemreq_addr,
      output imemreq_rdy,
      output imemresp_val,
      output imemresp_data,
      input  dmemreq_val,
      input  dmemreq_type,
      input  dmemreq_addr,
      input  dmemreq_wdata,
      output dmemreq_rdy,
      output dmemresp_val,
      output dmemresp_data
   );
endinterface

// File: rtl/tinyrv1_mem_responder.sv
// TinyRV1 imem/dmem responder: one shared word array, fixed-latency responses.
// Optional macro TINYRV1_MEM_MISALIGN_CHECK_EN enables misaligned-access trapping.
module tinyrv1_mem_responder #(
   parameter int WORDS   = 256,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   tinyrv1_mem_responder_if.slave bus,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        err
);

   localparam int AW = $clog2(WORDS);

   typedef enum logic {
      PORT_IMEM = 1'b0,
      PORT_DMEM = 1'b1
   } port_t;

   typedef struct packed {
      logic        val;
      port_t       port;
      logic [31:0] data;
   } stage_t;

   logic [31:0] mem [WORDS];
   stage_t      pipe [LATENCY];
   stage_t      tail;
   port_t       last_grant;

   logic          gnt_i;
   logic          gnt_d;
   logic          acc;
   logic          is_wr;
   logic [31:0]   req_addr;
   logic [AW-1:0] req_idx;
   logic [AW-1:0] wr_idx;
   logic [31:0]   wr_data;
   logic          wr_en;
   logic [31:0]   rd_word;
   logic [31:0]   resp_data;
   logic          req_mis;
   logic          load_mis;
   logic          unused_bits;

   // Alternate on conflict; last_grant follows every grant.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (!load_en) begin
         if (bus.imemreq_val && bus.dmemreq_val) begin
            gnt_i = (last_grant == PORT_DMEM);
            gnt_d = (last_grant == PORT_IMEM);
         end else begin
            gnt_i = bus.imemreq_val;
            gnt_d = bus.dmemreq_val;
         end
      end
   end

   assign bus.imemreq_rdy = gnt_i;
   assign bus.dmemreq_rdy = gnt_d;

   assign acc      = gnt_i | gnt_d;
   assign is_wr    = gnt_d & bus.dmemreq_type;
   assign req_addr = gnt_i ? bus.imemreq_addr : bus.dmemreq_addr;
   assign req_idx  = req_addr[AW+1:2];
   assign rd_word  = mem[req_idx];

`ifdef TINYRV1_MEM_MISALIGN_CHECK_EN
   assign req_mis  = |req_addr[1:0];
   assign load_mis = |load_addr[1:0];
`else
   assign req_mis  = 1'b0;
   assign load_mis = 1'b0;
`endif

   assign wr_en   = load_en ? !load_mis : (is_wr & !req_mis);
   assign wr_idx  = load_en ? load_addr[AW+1:2] : req_idx;
   assign wr_data = load_en ? load_data : bus.dmemreq_wdata;

   always_comb begin
      resp_data = rd_word;
      if (is_wr)
         resp_data = 32'h0;
      else if (req_mis)
         resp_data = 32'hDEADBEEF;
   end

   // Array has no reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= PORT_DMEM;
         for (int i = 0; i < LATENCY; i++)
            pipe[i] <= '0;
      end else begin
         if (acc)
            last_grant <= gnt_i ? PORT_IMEM : PORT_DMEM;
         pipe[0].val  <= acc;
         pipe[0].port <= gnt_d ? PORT_DMEM : PORT_IMEM;
         pipe[0].data <= acc ? resp_data : 32'h0;
         for (int i = 1; i < LATENCY; i++)
            pipe[i] <= pipe[i-1];
      end
   end

`ifdef TINYRV1_MEM_MISALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if ((acc && req_mis) || (load_en && load_mis))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

   assign tail = pipe[LATENCY-1];

   assign bus.imemresp_val  = tail.val && (tail.port == PORT_IMEM);
   assign bus.dmemresp_val  = tail.val && (tail.port == PORT_DMEM);
   assign bus.imemresp_data = bus.imemresp_val ? tail.data : 32'h0;
   assign bus.dmemresp_data = bus.dmemresp_val ? tail.data : 32'h0;

   // Address bits outside the word index are intentionally ignored.
   assign unused_bits = ^{bus.imemreq_addr[31:AW+2], bus.imemreq_addr[1:0],
                          bus.dmemreq_addr[31:AW+2], bus.dmemreq_addr[1:0],
                          load_addr[31:AW+2], load_addr[1:0]};

endmodule

// File: tb/tb_tinyrv1_mem_responder.sv
// Randomized bench for tinyrv1_mem_responder at LATENCY 1 and 3.
// Both instances share stimulus; a history-based model predicts outputs.
module tb_tinyrv1_mem_responder;

   localparam int WORDS = 256;
   localparam int HN    = 1024;
`ifdef TINYRV1_MEM_MISALIGN_CHECK_EN
   localparam bit MCHK = 1'b1;
`else
   localparam bit MCHK = 1'b0;
`endif

   typedef struct {
      bit          val;
      bit          port;
      logic [31:0] data;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv = 1'b0, dv = 1'b0, dt = 1'b0, le = 1'b0;
   logic [31:0] ia = '0, da = '0, dw = '0, la = '0, ld = '0;
   logic        err1, err3;

   tinyrv1_mem_responder_if b1();
   tinyrv1_mem_responder_if b3();

   assign b1.imemreq_val   = iv;
   assign b1.imemreq_addr  = ia;
   assign b1.dmemreq_val   = dv;
   assign b1.dmemreq_type  = dt;
   assign b1.dmemreq_addr  = da;
   assign b1.dmemreq_wdata = dw;
   assign b3.imemreq_val   = iv;
   assign b3.imemreq_addr  = ia;
   assign b3.dmemreq_val   = dv;
   assign b3.dmemreq_type  = dt;
   assign b3.dmemreq_addr  = da;
   assign b3.dmemreq_wdata = dw;

   tinyrv1_mem_responder #(.WORDS(WORDS), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1),
      .load_en(le), .load_addr(la), .load_data(ld), .err(err1)
   );

   tinyrv1_mem_responder #(.WORDS(WORDS), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .bus(b3),
      .load_en(le), .load_addr(la), .load_data(ld), .err(err3)
   );

   always #5 clk = ~clk;

   rec_t        hist [HN];
   logic [31:0] mm [WORDS];
   bit          m_last;
   bit          m_err;
   int          e = 0;
   int          nchk = 0;
   int          nfail = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, e);
      end
   endtask

   function automatic rec_t exp_at(int lat);
      rec_t r;
      int   idx;
      r = '{val: 1'b0, port: 1'b0, data: 32'h0};
      idx = e - lat + 1;
      if (idx >= 1)
         r = hist[idx % HN];
      return r;
   endfunction

   function automatic int widx(logic [31:0] a);
      return int'((a / 4) % WORDS);
   endfunction

   task automatic check_outs();
      rec_t r1, r3;
      bit   i1, d1, i3, d3;
      r1 = exp_at(1);
      r3 = exp_at(3);
      i1 = r1.val && !r1.port;
      d1 = r1.val && r1.port;
      i3 = r3.val && !r3.port;
      d3 = r3.val && r3.port;
      chk("l1_ival", 32'(b1.imemresp_val), 32'(i1));
      chk("l1_dval", 32'(b1.dmemresp_val), 32'(d1));
      chk("l1_idata", b1.imemresp_data, i1 ? r1.data : 32'h0);
      chk("l1_ddata", b1.dmemresp_data, d1 ? r1.data : 32'h0);
      chk("l3_ival", 32'(b3.imemresp_val), 32'(i3));
      chk("l3_dval", 32'(b3.dmemresp_val), 32'(d3));
      chk("l3_idata", b3.imemresp_data, i3 ? r3.data : 32'h0);
      chk("l3_ddata", b3.dmemresp_data, d3 ? r3.data : 32'h0);
      chk("err1", 32'(err1), 32'(m_err));
      chk("err3", 32'(err3), 32'(m_err));
   endtask

   task automatic cycle(
      input logic        i_v, input logic [31:0] i_a,
      input logic        d_v, input logic d_t,
      input logic [31:0] d_a, input logic [31:0] d_w,
      input logic        l_e, input logic [31:0] l_a,
      input logic [31:0] l_d
   );
      bit          gi, gd, mis;
      logic [31:0] a;
      rec_t        r;
      iv = i_v; ia = i_a; dv = d_v; dt = d_t;
      da = d_a; dw = d_w; le = l_e; la = l_a; ld = l_d;
      @(negedge clk);
      check_outs();
      gi = 1'b0;
      gd = 1'b0;
      if (!l_e) begin
         if (i_v && d_v) begin
            gi = m_last;
            gd = !m_last;
         end else begin
            gi = i_v;
            gd = d_v;
         end
      end
      chk("l1_irdy", 32'(b1.imemreq_rdy), 32'(gi));
      chk("l1_drdy", 32'(b1.dmemreq_rdy), 32'(gd));
      chk("l3_irdy", 32'(b3.imemreq_rdy), 32'(gi));
      chk("l3_drdy", 32'(b3.dmemreq_rdy), 32'(gd));
      r = '{val: 1'b0, port: 1'b0, data: 32'h0};
      if (l_e) begin
         if (MCHK && l_a[1:0] != 2'b00)
            m_err = 1'b1;
         else
            mm[widx(l_a)] = l_d;
      end else if (gi || gd) begin
         a = gi ? i_a : d_a;
         mis = MCHK && (a[1:0] != 2'b00);
         if (mis)
            m_err = 1'b1;
         r.val = 1'b1;
         r.port = gd;
         if (gd && d_t) begin
            r.data = 32'h0;
            if (!mis)
               mm[widx(a)] = d_w;
         end else begin
            r.data = mis ? 32'hDEADBEEF : mm[widx(a)];
         end
         m_last = gd;
      end
      hist[(e + 1) % HN] = r;
      @(posedge clk);
      e++;
      #1;
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      iv = 0; dv = 0; le = 0;
      rst = 1'b1;
      #1;
      for (int i = 0; i < HN; i++)
         hist[i] = '{val: 1'b0, port: 1'b0, data: 32'h0};
      m_last = 1'b1;
      m_err = 1'b0;
      @(negedge clk);
      check_outs();
      @(posedge clk);
      e++;
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 31)) << 2;
      if ($urandom % 4 == 0)
         a = a | (32'($urandom) << 10);
      if ($urandom % 8 == 0)
         a[1:0] = 2'($urandom);
      return a;
   endfunction

   logic [31:0] seen [7];

   initial begin
      do_reset();
      chk("rst_ival", 32'(b1.imemresp_val), 32'h0);
      chk("rst_err", 32'(err1), 32'h0);

      for (int i = 0; i < WORDS; i++)
         cycle(0, 0, 0, 0, 0, 0, 1, 32'(i * 4), $urandom);

      cycle(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h00000093);
      cycle(0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h00100113);
      cycle(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      chk("fetch0", b1.imemresp_data, 32'h00000093);
      cycle(1, 32'h4, 0, 0, 0, 0, 0, 0, 0);
      chk("fetch4", b1.imemresp_data, 32'h00100113);
      chk("fetch4_val", 32'(b1.imemresp_val), 32'h1);

      cycle(0, 0, 1, 1, 32'h100, 32'h12345678, 0, 0, 0);
      chk("sw_val", 32'(b1.dmemresp_val), 32'h1);
      chk("sw_data", b1.dmemresp_data, 32'h0);
      cycle(0, 0, 1, 0, 32'h100, 0, 0, 0, 0);
      chk("lw_data", b1.dmemresp_data, 32'h12345678);

      do_reset();
      cycle(1, 32'h0, 1, 0, 32'h100, 0, 0, 0, 0);
      chk("arb0_i", 32'(b1.imemresp_val), 32'h1);
      cycle(1, 32'h0, 1, 0, 32'h100, 0, 0, 0, 0);
      chk("arb1_d", 32'(b1.dmemresp_val), 32'h1);
      chk("arb1_data", b1.dmemresp_data, 32'h12345678);
      cycle(1, 32'h0, 1, 0, 32'h100, 0, 0, 0, 0);
      chk("arb2_i", b1.imemresp_data, 32'h00000093);

      idle();
      idle();
      idle();
      for (int k = 0; k < 7; k++) begin
         if (k < 4)
            cycle(1, 32'((k % 2) * 4), 0, 0, 0, 0, 0, 0, 0);
         else
            idle();
         seen[k] = b3.imemresp_data;
      end
      chk("lat3_e0", seen[0], 32'h0);
      chk("lat3_e1", seen[1], 32'h0);
      chk("lat3_e2", seen[2], 32'h00000093);
      chk("lat3_e3", seen[3], 32'h00100113);
      chk("lat3_e4", seen[4], 32'h00000093);
      chk("lat3_e5", seen[5], 32'h00100113);
      chk("lat3_e6", seen[6], 32'h0);

      cycle(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 32'h100, 0, 0, 0, 0);
      do_reset();
      idle();
      idle();
      idle();
      chk("flush_i", 32'(b3.imemresp_val), 32'h0);
      chk("flush_d", 32'(b3.dmemresp_val), 32'h0);
      cycle(0, 0, 1, 0, 32'h100, 0, 0, 0, 0);
      chk("retain", b1.dmemresp_data, 32'h12345678);

      cycle(0, 0, 1, 0, 32'h102, 0, 0, 0, 0);
      chk("mis_data", b1.dmemresp_data, MCHK ? 32'hDEADBEEF : 32'h12345678);
      chk("mis_err", 32'(err1), 32'(MCHK));
      idle();
      idle();
      chk("mis_sticky", 32'(err1), 32'(MCHK));

      do_reset();
      for (int n = 0; n < 1500; n++) begin
         cycle($urandom % 4 != 0, rnd_addr(),
               $urandom % 4 != 0, 1'($urandom), rnd_addr(), $urandom,
               $urandom % 16 == 0, rnd_addr(), $urandom);
         if (n % 500 == 499)
            do_reset();
      end
      for (int n = 0; n < 4; n++)
         idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule

// File: doc/tinyrv1_mem_responder.md
Name: tinyrv1_mem_responder

Overview:
- Memory-side responder for the TinyRV1 pipelined processor's instruction and data request interfaces. Accepts imem fetch requests and dmem load/store requests.
- Arbitrates both ports onto one single-ported word array.
- Returns responses after a fixed, parameterized latency.
- Serves as the simulation and FPGA memory behind the processor datapath and control.

Parameters:
- WORDS, 256, number of 32-bit words in the array; must be a power of two, minimum 16.
- LATENCY, 1, cycles from request acceptance to response valid; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- imemreq_val  input  1  fetch request valid.
- imemreq_rdy  output  1  fetch request accepted this cycle.
- imemreq_addr  input  32  fetch byte address.
- imemresp_val  output  1  fetch response valid.
- imemresp_data  output  32  fetched instruction word.
- dmemreq_val  input  1  data request valid.
- dmemreq_rdy  output  1  data request accepted this cycle.
- dmemreq_type  input  1  0 = read (lw), 1 = write (sw).
- dmemreq_addr  input  32  data byte address.
- dmemreq_wdata  input  32  store data.
- dmemresp_val  output  1  data response valid.
- dmemresp_data  output  32  load data; 0 for a write response.
- load_en  input  1  test/boot write port enable; takes priority over both request ports.
- load_addr  input  32  test write byte address.
- load_data  input  32  test write data.
- err  output  1  sticky misaligned-access flag (see Optional Feature).

Behaviour:
- Array index is addr[log2(WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo 4*WORDS.
- The array is not reset. Only control state is reset.
- Reset values: imemresp_val=0, dmemresp_val=0, imemresp_data=0, dmemresp_data=0, err=0, all pipeline valid bits 0, last_grant=DMEM.
- Requests and responses share one array port, so at most one access occurs per cycle.
- Arbitration (combinational rdy, registered last_grant):
  - load_en=1: both rdy=0; the array write occurs.
  - Only one port valid: that port's rdy=1.
  - Both ports valid: grant the port NOT equal to last_grant. last_grant updates to the granted port. With the reset value DMEM, imem wins the first conflict.
  - A port not valid never receives rdy=1. rdy never depends on rdy.
- Acceptance happens when val&rdy at the rising edge:
  - Reads sample array data at that edge.
  - Writes update the array at that edge. A read accepted on the next cycle returns the new data.
- Response pipeline: LATENCY register stages. Each stage holds {valid, port id, data}. An accepted request enters stage 1. Responses appear at the output exactly LATENCY cycles after acceptance.
- Exactly one of imemresp_val/dmemresp_val is 1 per response cycle. Response data is 0 when the matching val=0.
- There is no response backpressure. The consumer must accept every response, and there is no drop or reorder.
- Responses return in acceptance order.
- Back-to-back acceptance is permitted every cycle, giving a throughput of 1 request per cycle.
- Asynchronous reset asserted mid-operation clears all in-flight pipeline stages immediately; those responses are lost. Array contents are retained.
- Request inputs are not required to be stable while rdy=0. The requester re-presents the request until it sees rdy.

Optional Feature:
- Macro: TINYRV1_MEM_MISALIGN_CHECK_EN.
- Defined:
  - Any accepted request with addr[1:0]!=0 sets err=1. err stays 1 until rst.
  - A misaligned write is suppressed; the array is unchanged and a response with data 0 is still issued.
  - A misaligned read returns 32'hDEADBEEF.
  - load_en writes with load_addr[1:0]!=0 are also suppressed and set err.
- Undefined:
  - err is tied to 0.
  - addr[1:0] is ignored for all accesses, giving word-truncated behaviour.

Test Plan:
- Reset then preload: load_en writes 0x00000093 to addr 0x0 and 0x00100113 to addr 0x4. Then issue imemreq addr 0x0 and addr 0x4 on consecutive cycles (LATENCY=1) -> imemresp_val high on the following two cycles with data 0x00000093, then 0x00100113.
- dmem sw of 0x12345678 to 0x100, then lw from 0x100 on the next cycle -> first response has dmemresp_data=0; the second has 0x12345678.
- imem and dmem valid simultaneously for 3 cycles after reset -> grants are imem, dmem, imem. Responses return in that order with the correct port valid each cycle.
- LATENCY=3: accept a request at cycle t -> response valid at exactly t+3. Four back-to-back requests produce four consecutive response cycles.
- Assert rst for one cycle while 2 responses are in flight -> no response valid afterward. Data previously written to 0x100 still reads 0x12345678.
- With TINYRV1_MEM_MISALIGN_CHECK_EN defined: lw from 0x102 -> dmemresp_data=0xDEADBEEF and err=1 until reset. Without the macro: the same lw returns the word at 0x100 and err stays 0.
